stats_graph_renderer: RTL and testbench

STATS_GRAPH_RENDERER -- requirements
Module: stats_graph_renderer

---
 rtl/stats_graph_renderer_pkg.sv | 50 +++++
 rtl/vga_if.sv | 13 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/stats_graph_renderer.sv | 142 ++++++++++++++
 tb/tb_stats_graph_renderer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/stats_graph_renderer_pkg.sv
// stats_graph_renderer_pkg
// Shared constants, types and helpers for the population graph overlay.
// Board/graph geometry, sample scaling, FSM state encoding and the
// per-pixel pipeline stage record.
package stats_graph_renderer_pkg;

   localparam int BOARD_SIZE = 480;
   localparam int POP_WIDTH  = $clog2(BOARD_SIZE*BOARD_SIZE+1);
   localparam int GRAPH_SHIFT = 11;
   localparam logic [11:0] GRAPH_COLOR = 12'h0FF;

   localparam logic [9:0] SCREEN_WIDTH   = 10'd640;
   localparam logic [9:0] SCREEN_HEIGHT  = 10'd480;
   localparam logic [9:0] GRAPH_ORIGIN_X = 10'd510;
   localparam logic [9:0] GRAPH_ORIGIN_Y = 10'd10;
   localparam logic [9:0] GRAPH_WIDTH    = 10'd128;
   localparam logic [9:0] GRAPH_HEIGHT   = 10'd128;
   localparam int GRAPH_SAMPLE_PERIOD    = 2;

   localparam int HEIGHT_W   = 7;   // stored sample height
   localparam int IDX_W      = 7;   // history index / column / row
   localparam int HIST_DEPTH = 128;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_DRAIN
   } graph_state_t;

   // Everything the output stage needs besides the RAM read data.
   typedef struct packed {
      logic             in_win;
      logic [IDX_W-1:0] row;
      logic             hsync;
      logic             vsync;
      logic             blank;
      logic             clear;
   } pix_stage_t;

   // Scale a live-cell count into a bar height, saturated to the graph.
   function automatic logic [HEIGHT_W-1:0] pop_to_height(input logic [POP_WIDTH-1:0] pop);
      logic [POP_WIDTH-1:0] s;
      s = pop >> GRAPH_SHIFT;
      if (s > POP_WIDTH'(GRAPH_HEIGHT - 10'd1))
         return HEIGHT_W'(GRAPH_HEIGHT - 10'd1);
      return HEIGHT_W'(s);
   endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if
// Raster position and sync bundle from the timing generator.
// src: driven by the timing source; dst: consumed by overlay renderers.
interface vga_if;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       hsync;
   logic       vsync;
   logic       blank;

   modport src (output hcount, vcount, hsync, vsync, blank);
   modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo
// Small show-ahead FIFO holding graph samples until vertical blank.
//   push/din : write request and data (ignored when full unless popping)
//   pop      : consume dout (ignored when empty)
//   dout     : oldest entry, valid while !empty
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap for free.
module sample_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so a push against a full FIFO
   // still lands when it coincides with a pop.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wp] <= din;
   end

endmodule

// File: rtl/stats_graph_renderer.sv
// stats_graph_renderer
// Scrolling population bar graph overlaid on the VGA raster.
//   clk_in, rst_n_in : pixel clock, async active-low reset
//   vga              : incoming raster position/sync/blank
//   sample_valid_in  : one pulse per generation, pop_in valid with it
//   pixel_out        : graph color or 0, two clocks behind vga
//   hsync/vsync/blank_out : vga syncs delayed to match pixel_out
//   overflow_out     : sticky, a decimated sample was dropped
// Samples queue in a small FIFO and are only committed to the history RAM
// during vertical blank, so a displayed frame never tears.
module stats_graph_renderer
   import stats_graph_renderer_pkg::*;
(
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   vga_if.dst                   vga,
   input  logic                 sample_valid_in,
   input  logic [POP_WIDTH-1:0] pop_in,
   output logic [11:0]          pixel_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 blank_out,
   output logic                 overflow_out
);
   localparam int DEC_W = (GRAPH_SAMPLE_PERIOD > 1) ? $clog2(GRAPH_SAMPLE_PERIOD) : 1;

   graph_state_t      state;
   logic [IDX_W-1:0]  clr_addr;
   logic [IDX_W-1:0]  wr_ptr;     // always the oldest history entry
   logic [DEC_W-1:0]  dec_cnt;

   logic              push_req, fifo_pop, fifo_full, fifo_empty, in_vblank;
   logic [HEIGHT_W-1:0] fifo_dout;

   // decimation
   assign push_req = sample_valid_in && (dec_cnt == DEC_W'(GRAPH_SAMPLE_PERIOD-1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)            dec_cnt <= '0;
      else if (sample_valid_in) dec_cnt <= push_req ? '0 : dec_cnt + 1'b1;
   end

   sample_fifo #(.WIDTH(HEIGHT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .push    (push_req),
      .din     (pop_to_height(pop_in)),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                             overflow_out <= 1'b0;
      else if (push_req && fifo_full && !fifo_pop) overflow_out <= 1'b1;
   end

   // commit FSM
   assign in_vblank = (vga.vcount >= SCREEN_HEIGHT);
   assign fifo_pop  = (state == ST_DRAIN) && !fifo_empty && in_vblank;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
         wr_ptr   <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == IDX_W'(HIST_DEPTH-1)) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (in_vblank && !fifo_empty) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (fifo_pop) wr_ptr <= wr_ptr + 1'b1;
               if (fifo_empty || !in_vblank) state <= ST_IDLE;
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // history RAM: one write port (clear or drain), one synchronous read port
   logic [HEIGHT_W-1:0] hist [HIST_DEPTH];
   logic                ram_we;
   logic [IDX_W-1:0]    ram_waddr, rd_idx, col, row;
   logic [HEIGHT_W-1:0] ram_wdata, rd_data;

   assign ram_we    = (state == ST_CLEAR) || fifo_pop;
   assign ram_waddr = (state == ST_CLEAR) ? clr_addr : wr_ptr;
   assign ram_wdata = (state == ST_CLEAR) ? '0 : fifo_dout;

   // column 0 shows the oldest sample; the index wraps modulo the depth
   assign col    = IDX_W'(vga.hcount - GRAPH_ORIGIN_X);
   assign row    = IDX_W'(vga.vcount - GRAPH_ORIGIN_Y);
   assign rd_idx = wr_ptr + col;

   always_ff @(posedge clk_in) begin
      if (ram_we) hist[ram_waddr] <= ram_wdata;
      rd_data <= hist[rd_idx];
   end

   // pixel pipeline: stage 1 alongside the RAM read, stage 2 is the output
   pix_stage_t s0, s1;
   logic       lit;

   always_comb begin
      s0        = '0;
      s0.in_win = (vga.hcount >= GRAPH_ORIGIN_X) && (vga.hcount < GRAPH_ORIGIN_X + GRAPH_WIDTH) &&
                  (vga.vcount >= GRAPH_ORIGIN_Y) && (vga.vcount < GRAPH_ORIGIN_Y + GRAPH_HEIGHT);
      s0.row    = row;
      s0.hsync  = vga.hsync;
      s0.vsync  = vga.vsync;
      s0.blank  = vga.blank;
      s0.clear  = (state == ST_CLEAR);
   end

   // a bar of height h lights the bottom h rows of its column
   assign lit = s1.in_win && !s1.blank && !s1.clear &&
                ((IDX_W'(GRAPH_HEIGHT - 10'd1) - s1.row) < rd_data);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1        <= '0;
         s1.blank  <= 1'b1;
         pixel_out <= 12'h000;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         blank_out <= 1'b1;
      end else begin
         s1        <= s0;
         pixel_out <= lit ? GRAPH_COLOR : 12'h000;
         hsync_out <= s1.hsync;
         vsync_out <= s1.vsync;
         blank_out <= s1.blank;
      end
   end

endmodule

// File: tb/tb_stats_graph_renderer.sv
module tb_stats_graph_renderer;
   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b1;
   logic        sample_valid_in = 1'b0;
   logic [17:0] pop_in = '0;
   logic [11:0] pixel_out;
   logic        hsync_out, vsync_out, blank_out, overflow_out;

   always #5 clk_in = ~clk_in;

   vga_if vga();

   stats_graph_renderer dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .vga            (vga),
      .sample_valid_in(sample_valid_in),
      .pop_in         (pop_in),
      .pixel_out      (pixel_out),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .blank_out      (blank_out),
      .overflow_out   (overflow_out)
   );

   typedef struct {
      logic [11:0] pix;
      logic [11:0] lit;
      bit          probe;
      logic        hs, vs, bl;
   } exp_t;

   // behavioural model: history as an oldest-first list of 128 heights
   exp_t        exp_q[$];
   logic [6:0]  hist_q[$];
   logic [6:0]  fifo_q[$];
   int          dec_m;
   bit          ovf_m;
   int          edges;
   int          checks = 0;
   int          errors = 0;

   bit          probe_on = 0;
   logic [6:0]  probe_h [128];
   bit          use_pops = 0;
   logic [17:0] pops [10];
   int          pop_idx, pulse_left, act_idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] lit_of(input int h, input int v, input logic bl, input int height);
      if (h >= 510 && h < 638 && v >= 10 && v < 138 && !bl && (127 - (v - 10)) < height)
         return 12'h0FF;
      return 12'h000;
   endfunction

   function automatic bit in_win(input int h, input int v);
      return (h >= 510 && h < 638 && v >= 10 && v < 138);
   endfunction

   task automatic step(input int h, input int v, input logic hs, input logic vs,
                       input logic bl, input logic sv, input logic [17:0] pop);
      exp_t e;
      int   ht;
      vga.hcount = 10'(h);
      vga.vcount = 10'(v);
      vga.hsync  = hs;
      vga.vsync  = vs;
      vga.blank  = bl;
      sample_valid_in = sv;
      pop_in = pop;
      e.hs = hs; e.vs = vs; e.bl = bl;
      e.pix   = (edges < 128 || !in_win(h, v)) ? 12'h000 : lit_of(h, v, bl, int'(hist_q[h-510]));
      e.probe = probe_on;
      e.lit   = in_win(h, v) ? lit_of(h, v, bl, int'(probe_h[h-510])) : 12'h000;
      exp_q.push_back(e);
      if (sv) begin
         if (dec_m == 1) begin
            ht = int'(pop) / 2048;
            if (ht > 127) ht = 127;
            if (fifo_q.size() < 4) fifo_q.push_back(7'(ht));
            else ovf_m = 1;
         end
         dec_m = (dec_m + 1) % 2;
      end
      if (v >= 480 && edges >= 128)
         while (fifo_q.size() > 0) begin
            hist_q.push_back(fifo_q.pop_front());
            void'(hist_q.pop_front());
         end
      @(posedge clk_in);
      #1;
      edges++;
      if (exp_q.size() == 2) begin
         e = exp_q.pop_front();
         check("pixel", 32'(pixel_out), 32'(e.pix));
         check("hsync", 32'(hsync_out), 32'(e.hs));
         check("vsync", 32'(vsync_out), 32'(e.vs));
         check("blank", 32'(blank_out), 32'(e.bl));
         if (e.probe) check("probe_pixel", 32'(pixel_out), 32'(e.lit));
      end
      check("overflow", 32'(overflow_out), 32'(ovf_m));
   endtask

   task automatic do_line(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) begin
         logic        sv;
         logic [17:0] pop;
         sv  = 1'b0;
         pop = 18'($urandom);
         if (v < 480) begin
            act_idx++;
            if (pulse_left > 0 && act_idx % 97 == 37) begin
               sv = 1'b1;
               pulse_left--;
               if (use_pops) begin
                  pop = pops[pop_idx];
                  pop_idx++;
               end
            end
         end
         step(h, v, 1'($urandom), 1'($urandom),
              (v >= 480) ? 1'b1 : 1'($urandom_range(0, 15) == 0), sv, pop);
      end
   endtask

   task automatic frame(input int np, input bit no_vblank = 0);
      int rows_a [6] = '{8, 9, 10, 11, 25, 26};
      int rows_b [8] = '{132, 133, 134, 135, 136, 137, 138, 139};
      pulse_left = np; act_idx = 0; pop_idx = 0;
      foreach (rows_a[i]) do_line(rows_a[i], 506, 641);
      for (int k = 0; k < 10; k++) do_line($urandom_range(12, 131), 506, 641);
      foreach (rows_b[i]) do_line(rows_b[i], 506, 641);
      if (!no_vblank) begin
         do_line(480, 506, 641);
         do_line(481, 506, 641);
      end
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      #1;
      check("rst_pixel", 32'(pixel_out), 32'h0);
      check("rst_hsync", 32'(hsync_out), 32'h0);
      check("rst_vsync", 32'(vsync_out), 32'h0);
      check("rst_blank", 32'(blank_out), 32'h1);
      check("rst_overflow", 32'(overflow_out), 32'h0);
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      fifo_q.delete();
      hist_q.delete();
      for (int i = 0; i < 128; i++) hist_q.push_back(7'd0);
      exp_q.delete();
      dec_m = 0; ovf_m = 0; edges = 0;
   endtask

   task automatic clear_probe();
      for (int i = 0; i < 128; i++) probe_h[i] = 7'd0;
   endtask

   initial begin
      vga.hcount = '0; vga.vcount = '0; vga.hsync = 0; vga.vsync = 0; vga.blank = 1;
      clear_probe();
      #2;
      do_reset();

      // one push of a saturating-range count; newest column shows rows 26..137
      use_pops = 1;
      pops[0] = 18'd230400; pops[1] = 18'd230400;
      frame(2);
      check("model_col127_h112", 32'(hist_q[127]), 32'd112);
      check("model_px_637_26", 32'(lit_of(637, 26, 0, int'(hist_q[127]))), 32'h0FF);
      check("model_px_637_25", 32'(lit_of(637, 25, 0, int'(hist_q[127]))), 32'h000);
      clear_probe(); probe_h[127] = 7'd112;
      probe_on = 1; frame(0); probe_on = 0;

      // decimation: heights 2 and 4 land in the two newest columns
      do_reset();
      pops[0] = 18'd2048; pops[1] = 18'd4096; pops[2] = 18'd6144; pops[3] = 18'd8192;
      frame(4);
      check("model_col126_h2", 32'(hist_q[126]), 32'd2);
      check("model_col127_h4", 32'(hist_q[127]), 32'd4);
      clear_probe(); probe_h[126] = 7'd2; probe_h[127] = 7'd4;
      probe_on = 1; frame(0); probe_on = 0;

      // five pushes in one frame: fifth is dropped, overflow sticks
      do_reset();
      for (int k = 0; k < 10; k++) pops[k] = 18'(2048 * (k + 1));
      frame(10);
      check("ovf_set", 32'(overflow_out), 32'h1);
      check("model_col124_h2", 32'(hist_q[124]), 32'd2);
      check("model_col127_h8", 32'(hist_q[127]), 32'd8);
      clear_probe();
      probe_h[124] = 7'd2; probe_h[125] = 7'd4; probe_h[126] = 7'd6; probe_h[127] = 7'd8;
      probe_on = 1; frame(0); probe_on = 0;
      check("ovf_sticky", 32'(overflow_out), 32'h1);

      // randomized traffic
      use_pops = 0;
      for (int f = 0; f < 6; f++) frame($urandom_range(0, 9));

      // reset while draining three pending entries
      frame(6, 1);
      step(506, 480, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0);
      do_reset();
      do_line(130, 511, 641);   // stale RAM ahead of the clear sweep must stay dark
      clear_probe();
      probe_on = 1; frame(0); probe_on = 0;
      check("ovf_after_rst", 32'(overflow_out), 32'h0);

      frame($urandom_range(1, 8));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
